// File: rtl/imm_gen_pipe_if.sv
// Valid/ready handshake bundle for the immediate generator.
// The master is the fetch/execute side and the slave is the generator.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [31:0]     out_instr;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_instr, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_instr, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator for the decode stage.
// A two-entry output buffer sits behind the combinational decoder.
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter bit EN_J = 1'b1,
    parameter bit EN_W = 1'b0
) (
    input logic         clk,
    input logic         reset,
    imm_gen_pipe_if.slave bus
);
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    // The 32-bit word opcodes only make sense on a 64-bit datapath.
    localparam bit W_OK = EN_W && (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [31:0]     instr;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t      state;
    entry_t      dec;
    entry_t      out_q;
    entry_t      skid_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        accept;
    logic        drain;
    logic [31:0] ins;

    assign ins = bus.in_instr;

    always_comb begin
        dec         = '0;
        dec.instr   = ins;
        dec.illegal = 1'b0;
        case (ins[6:0])
            OP_IMM, OP_LOAD: begin
                dec.imm = XLEN'($signed(ins[31:20]));
                dec.fmt = FMT_I;
            end
            OP_JALR: begin
                if (EN_J) begin
                    dec.imm = XLEN'($signed(ins[31:20]));
                    dec.fmt = FMT_I;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_IMM32: begin
                if (W_OK) begin
                    dec.imm = XLEN'($signed(ins[31:20]));
                    dec.fmt = FMT_I;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_STORE: begin
                dec.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
                dec.fmt = FMT_S;
            end
            OP_BRANCH: begin
                dec.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                dec.fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                if (EN_J) begin
                    dec.imm = XLEN'($signed({ins[31:12], 12'b0}));
                    dec.fmt = FMT_U;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_JAL: begin
                if (EN_J) begin
                    dec.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                    dec.fmt = FMT_J;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        if (dec.illegal) begin
            dec.imm = '0;
            dec.fmt = FMT_NONE;
        end
    end

    assign accept = bus.in_valid & in_ready_q;
    assign drain  = out_valid_q & bus.out_ready;

    // in_ready and out_valid are registered alongside the state so that
    // neither handshake side sees a combinational path from the other.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        out_q       <= dec;
                        out_valid_q <= 1'b1;
                        state       <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && drain) begin
                        out_q <= dec;
                    end else if (accept) begin
                        skid_q     <= dec;
                        in_ready_q <= 1'b0;
                        state      <= S_TWO;
                    end else if (drain) begin
                        out_valid_q <= 1'b0;
                        state       <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (drain) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= S_ONE;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_instr   = out_q.instr;
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_illegal = out_q.illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives three generator configurations with one shared stimulus stream and
// compares every output against a two-deep FIFO model of decoded instructions.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        out_ready = 1'b1;

    int          assert_count = 0;
    int          fail_count = 0;
    logic [31:0] q[$];
    bit          started = 1'b0;
    bit          post_reset = 1'b0;
    bit          model_acc = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(32)) bnj ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.in_instr  = in_instr;
    assign b32.out_ready = out_ready;
    assign bnj.in_valid  = in_valid;
    assign bnj.in_instr  = in_instr;
    assign bnj.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_instr  = in_instr;
    assign b64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .EN_J(1'b1), .EN_W(1'b0)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    imm_gen_pipe #(.XLEN(32), .EN_J(1'b0), .EN_W(1'b0)) dutnj (.clk(clk), .reset(reset), .bus(bnj));
    imm_gen_pipe #(.XLEN(64), .EN_J(1'b1), .EN_W(1'b1)) dut64 (.clk(clk), .reset(reset), .bus(b64));

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference decode written as plain signed arithmetic on the field values.
    task automatic refDecode(input logic [31:0] ins, input bit en_j, input bit en_w,
                             output longint imm, output int fmt, output bit ill);
        imm = 0;
        fmt = 0;
        ill = 1'b0;
        case (ins[6:0])
            7'h13, 7'h03: begin imm = longint'($signed(ins[31:20])); fmt = 1; end
            7'h67: if (en_j) begin imm = longint'($signed(ins[31:20])); fmt = 1; end else ill = 1'b1;
            7'h1B: if (en_w) begin imm = longint'($signed(ins[31:20])); fmt = 1; end else ill = 1'b1;
            7'h23: begin imm = longint'($signed({ins[31:25], ins[11:7]})); fmt = 2; end
            7'h63: begin
                imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
                fmt = 3;
            end
            7'h37, 7'h17: if (en_j) begin imm = longint'($signed(ins[31:12])) * 4096; fmt = 4; end else ill = 1'b1;
            7'h6F: if (en_j) begin
                imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
                fmt = 5;
            end else ill = 1'b1;
            default: ill = 1'b1;
        endcase
    endtask

    task automatic checkBus(input string name, input logic ov, input logic ir,
                            input logic [63:0] imm, input logic [31:0] ins, input logic [2:0] fmt,
                            input logic ill, input int xlen, input bit en_j, input bit en_w);
        longint eimm;
        int     efmt;
        bit     eill;
        logic [63:0] emask;
        checkOutput({name, " out_valid"}, 64'(ov), 64'(q.size() > 0));
        checkOutput({name, " in_ready"}, 64'(ir), 64'(q.size() < 2));
        if (q.size() > 0) begin
            refDecode(q[0], en_j, en_w, eimm, efmt, eill);
            emask = eimm;
            if (xlen == 32) emask = {32'b0, emask[31:0]};
            checkOutput({name, " out_imm"}, imm, emask);
            checkOutput({name, " out_instr"}, 64'(ins), 64'(q[0]));
            checkOutput({name, " out_fmt"}, 64'(fmt), 64'(efmt));
            checkOutput({name, " out_illegal"}, 64'(ill), 64'(eill));
        end else if (post_reset) begin
            checkOutput({name, " reset out_imm"}, imm, 64'd0);
            checkOutput({name, " reset out_instr"}, 64'(ins), 64'd0);
            checkOutput({name, " reset out_fmt"}, 64'(fmt), 64'd0);
            checkOutput({name, " reset out_illegal"}, 64'(ill), 64'd0);
        end
    endtask

    // Model update: the buffer behaves as a FIFO of depth two.
    initial forever begin
        bit acc;
        bit drn;
        @(posedge clk);
        model_acc = 1'b0;
        if (reset) begin
            q.delete();
            started    = 1'b1;
            post_reset = 1'b1;
        end else if (started) begin
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back(in_instr);
                post_reset = 1'b0;
                model_acc  = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            checkBus("x32", b32.out_valid, b32.in_ready, {32'b0, b32.out_imm}, b32.out_instr,
                     b32.out_fmt, b32.out_illegal, 32, 1'b1, 1'b0);
            checkBus("noj", bnj.out_valid, bnj.in_ready, {32'b0, bnj.out_imm}, bnj.out_instr,
                     bnj.out_fmt, bnj.out_illegal, 32, 1'b0, 1'b0);
            checkBus("x64", b64.out_valid, b64.in_ready, b64.out_imm, b64.out_instr,
                     b64.out_fmt, b64.out_illegal, 64, 1'b1, 1'b1);
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rdy, input logic rst);
        in_valid  = v;
        in_instr  = ins;
        out_ready = rdy;
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [31:0] ins, input logic rdy);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, ins, rdy, 1'b0);
            if (model_acc) return;
        end
        checkOutput("accept timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [31:0] directed[11];
        logic [6:0]  ops[12];
        logic [31:0] r;
        directed = '{32'hFFF00093, 32'h00112623, 32'hFE000CE3, 32'h123450B7, 32'hFFDFF06F,
                     32'h800000B7, 32'h0000007F, 32'hFFF0051B, 32'h00008067, 32'h00C12083,
                     32'hFFFFF097};
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h1B, 7'h7F, 7'h33, 7'h00};

        // Reset held for two cycles with a valid instruction offered.
        applyStimulus(1'b1, 32'hFFF00093, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'hFFF00093, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        foreach (directed[i]) sendWord(directed[i], 1'b1);
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: two accepts fill the buffer, the third stalls.
        sendWord(32'h00A00513, 1'b0);
        sendWord(32'h00B02223, 1'b0);
        repeat (3) applyStimulus(1'b1, 32'h00C000EF, 1'b0, 1'b0);
        sendWord(32'h00C000EF, 1'b1);
        sendWord(32'hFE0008E3, 1'b1);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            sendWord({r[31:7], ops[i]}, 1'b1);
        end
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset while both entries are occupied must discard them.
        sendWord(32'h12345037, 1'b0);
        sendWord(32'h00100093, 1'b0);
        applyStimulus(1'b1, 32'h00200113, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            applyStimulus($urandom_range(0, 3) != 0,
                          {r[31:7], ops[$urandom_range(0, 11)]},
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 99) == 0);
        end
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised RISC-V immediate generator for the decode stage. Accepts 32-bit instructions over a valid/ready handshake and decodes I, S, B, U and J immediates, sign-extended to XLEN. It also reports the format and flags opcodes it does not support. A 2-entry output buffer registers all outputs and gives full-throughput backpressure between fetch and the execute/ALU-operand path.

Parameters:
XLEN, 32, immediate output width; legal values 32 and 64.
EN_J, 1, 1 = decode JAL/JALR/LUI/AUIPC; 0 = only I, I_LD, S, B are legal.
EN_W, 0, 1 = decode OP-IMM-32 (0011011) as I-type; only legal with XLEN=64.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  in_instr is valid this cycle.
in_ready  out  1  block can accept an instruction this cycle.
in_instr  in  32  instruction word.
out_valid  out  1  output fields are valid.
out_ready  in  1  consumer accepts the output this cycle.
out_imm  out  XLEN  sign-extended immediate.
out_instr  out  32  instruction passthrough, aligned with out_imm.
out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
out_illegal  out  1  opcode not supported under current parameters.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: out_valid=0, out_imm=0, out_instr=0, out_fmt=0, out_illegal=0, both buffer entries invalid. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation discards all buffered entries; no output handshake completes in the reset cycle.
- Decode is combinational on in_instr[6:0]; the result is captured in the buffer on accept (in_valid & in_ready).
  - I (0010011, 0000011, 1100111 when EN_J): imm = sext(instr[31:20]).
  - S (0100011): imm = sext({instr[31:25], instr[11:7]}).
  - B (1100011): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U (0110111, 0010111; EN_J only): imm = sext({instr[31:12], 12'b0}). Bit 31 is sign-extended when XLEN=64.
  - J (1101111; EN_J only): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other opcode, or a gated-off opcode: imm=0, fmt=0, illegal=1. The entry is still passed downstream, never dropped.
- Latency: 1 cycle. An instruction accepted in cycle N presents on the outputs in cycle N+1 if the buffer was empty.
- Buffer state machine:
  - EMPTY: in_ready=1, out_valid=0. Accept -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept and drain in the same cycle -> ONE, outputs replaced by the new entry.
    - Accept only -> TWO, new entry goes to the skid slot.
    - Drain only -> EMPTY.
  - TWO: in_ready=0, out_valid=1. Drain -> ONE, skid entry moves to the output. in_valid is ignored.
- Ordering is strict FIFO. Output fields stay stable while out_valid=1 and out_ready=0.
- in_ready is a registered state decode, with no combinational path from out_ready.
- Sustained throughput is 1 instruction/cycle when out_ready is held high.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid=1 -> out_valid=0, out_imm=0, in_ready=1 after release, and no output appears.
- I and S types: 0xFFF00093 (addi x1,x0,-1) -> out_imm=0xFFFFFFFF, fmt=1, illegal=0 one cycle later. Then 0x00112623 (sw x1,12(x2)) -> imm=0x0000000C, fmt=2.
- B, U and J types: 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt=3. 0x123450B7 (lui) -> 0x12345000, fmt=4. 0xFFDFF06F (jal -4) -> 0xFFFFFFFC, fmt=5. With XLEN=64, the lui 0x800000B7 -> 0xFFFFFFFF80000000.
- Gating/illegal: EN_J=0 with 0x123450B7 -> imm=0, fmt=0, illegal=1, out_instr=0x123450B7. Opcode 0x7F -> illegal=1.
- Backpressure: stream 4 instructions with out_ready=0 -> in_ready drops after 2 accepts and outputs stay stable. Release out_ready -> all 4 emerge in order with no loss or duplication.
- Throughput/mid-stream reset: out_ready=1 with a back-to-back stream of 8 -> 8 outputs in 8 consecutive cycles. Reset asserted while in TWO -> EMPTY next cycle, and buffered entries never appear.
